pingpong_frame_buffer: RTL and testbench

Double-buffered pixel store between the tracer (writer) and the display scan-out (reader). It generalises the single-bank dual-port RAM to parametrised geometry and pixel width, adds write enable and a registered read port, and provides a front/back bank swap handshake. The display always reads a complete frame while the tracer fills the other bank. Banks swap only at display vsync, and only after the writer has declared its frame finished.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/pingpong_frame_buffer_if.sv | 38 +++
 rtl/fb_bank.sv | 40 ++++
 rtl/pingpong_frame_buffer.sv | 136 +++++++++++++
 tb/tb_pingpong_frame_buffer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer: default geometry,
// FSM state encoding and the {row, col} address helper.
package fb_pkg;

    localparam int FB_COL_W      = 7;
    localparam int FB_ROW_W      = 6;
    localparam int FB_DATA_W     = 12;
    localparam int FB_FCNT_W     = 8;
    localparam int FB_ADDR_MAX_W = 32;

    localparam logic [0:0] FB_FILLING = 1'b0;
    localparam logic [0:0] FB_FULL    = 1'b1;

    // Callers zero-extend row/col to FB_ADDR_MAX_W and size-cast the result.
    function automatic logic [FB_ADDR_MAX_W-1:0] fb_addr(
        input logic [FB_ADDR_MAX_W-1:0] row,
        input logic [FB_ADDR_MAX_W-1:0] col,
        input int unsigned              col_w
    );
        return (row << col_w) | col;
    endfunction

endpackage

// File: rtl/pingpong_frame_buffer_if.sv
// Writer/reader bundle of the ping-pong frame buffer. The master side is the
// tracer plus display scan-out; the slave side is the buffer itself.
interface pingpong_frame_buffer_if #(
    parameter int COL_W  = fb_pkg::FB_COL_W,
    parameter int ROW_W  = fb_pkg::FB_ROW_W,
    parameter int DATA_W = fb_pkg::FB_DATA_W,
    parameter int FCNT_W = fb_pkg::FB_FCNT_W
);

    logic              wr_en;
    logic [COL_W-1:0]  wr_col;
    logic [ROW_W-1:0]  wr_row;
    logic [DATA_W-1:0] wr_data;
    logic              wr_frame_done;
    logic              wr_ready;
    logic              wr_drop;
    logic              rd_en;
    logic [COL_W-1:0]  rd_col;
    logic [ROW_W-1:0]  rd_row;
    logic              rd_vsync;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              front_bank;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output wr_en, wr_col, wr_row, wr_data, wr_frame_done,
        output rd_en, rd_col, rd_row, rd_vsync,
        input  wr_ready, wr_drop, rd_data, rd_valid, front_bank, frame_cnt
    );

    modport slave (
        input  wr_en, wr_col, wr_row, wr_data, wr_frame_done,
        input  rd_en, rd_col, rd_row, rd_vsync,
        output wr_ready, wr_drop, rd_data, rd_valid, front_bank, frame_cnt
    );

endinterface

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM, synchronous write, registered read.
// Only the read register is reset; the array contents are not.
module fb_bank #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_r;

    // Pixel store write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register; holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered pixel store: the tracer fills the back bank while the display
// reads the front bank; banks swap at vsync once the writer has finished a frame.
module pingpong_frame_buffer
    import fb_pkg::*;
#(
    parameter int COL_W  = FB_COL_W,
    parameter int ROW_W  = FB_ROW_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int FCNT_W = FB_FCNT_W
) (
    input logic                    clk,
    input logic                    rst,
    pingpong_frame_buffer_if.slave fb
);

    localparam int ADDR_W = COL_W + ROW_W;

    logic [0:0]        state_r;
    logic              front_bank_r;
    logic [FCNT_W-1:0] frame_cnt_r;
    logic              wr_drop_r;
    logic              rd_valid_r;
    logic              rd_sel_r;

    logic              wr_ready_s;
    logic              wr_fire_s;
    logic              we0_s;
    logic              we1_s;
    logic              re0_s;
    logic              re1_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] q0_s;
    logic [DATA_W-1:0] q1_s;
    logic [DATA_W-1:0] rd_data_s;

    // Bank steering: writes hit only the back bank, reads only the front bank.
    always_comb begin
        wr_ready_s = (state_r == FB_FILLING);
        wr_fire_s  = fb.wr_en & wr_ready_s;
        we0_s      = wr_fire_s & front_bank_r;
        we1_s      = wr_fire_s & ~front_bank_r;
        re0_s      = fb.rd_en & ~front_bank_r;
        re1_s      = fb.rd_en & front_bank_r;
        wr_addr_s  = ADDR_W'(fb_addr(FB_ADDR_MAX_W'(fb.wr_row), FB_ADDR_MAX_W'(fb.wr_col), COL_W));
        rd_addr_s  = ADDR_W'(fb_addr(FB_ADDR_MAX_W'(fb.rd_row), FB_ADDR_MAX_W'(fb.rd_col), COL_W));
    end

    // Swap FSM: FILLING until frame_done, then FULL until the next vsync.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FB_FILLING;
            front_bank_r <= 1'b0;
            frame_cnt_r  <= {FCNT_W{1'b0}};
        end else begin
            case (state_r)
                FB_FILLING: begin
                    if (fb.wr_frame_done) begin
                        state_r <= FB_FULL;
                    end
                end
                FB_FULL: begin
                    if (fb.rd_vsync) begin
                        state_r      <= FB_FILLING;
                        front_bank_r <= ~front_bank_r;
                        frame_cnt_r  <= frame_cnt_r + FCNT_W'(1);
                    end
                end
                default: begin
                    state_r <= FB_FILLING;
                end
            endcase
        end
    end

    // Sticky drop flag for writer activity while the back bank is locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop_r <= 1'b0;
        end else if (!wr_ready_s && (fb.wr_en || fb.wr_frame_done)) begin
            wr_drop_r <= 1'b1;
        end
    end

    // Read-side bookkeeping; the mux select only moves with a read so rd_data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_sel_r   <= 1'b0;
        end else begin
            rd_valid_r <= fb.rd_en;
            if (fb.rd_en) begin
                rd_sel_r <= front_bank_r;
            end
        end
    end

    fb_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (we0_s),
        .wr_addr (wr_addr_s),
        .wr_data (fb.wr_data),
        .rd_en   (re0_s),
        .rd_addr (rd_addr_s),
        .rd_data (q0_s)
    );

    fb_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (we1_s),
        .wr_addr (wr_addr_s),
        .wr_data (fb.wr_data),
        .rd_en   (re1_s),
        .rd_addr (rd_addr_s),
        .rd_data (q1_s)
    );

    // Output select from the registered bank-of-last-read.
    always_comb begin
        if (rd_sel_r) begin
            rd_data_s = q1_s;
        end else begin
            rd_data_s = q0_s;
        end
    end

    assign fb.wr_ready   = wr_ready_s;
    assign fb.wr_drop    = wr_drop_r;
    assign fb.rd_data    = rd_data_s;
    assign fb.rd_valid   = rd_valid_r;
    assign fb.front_bank = front_bank_r;
    assign fb.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: table of per-cycle vectors with expected
// status outputs, plus a read scoreboard queue consumed one cycle after rd_en.
module tb_pingpong_frame_buffer;

    logic clk;
    logic rst;

    pingpong_frame_buffer_if #(.COL_W(7), .ROW_W(6), .DATA_W(12), .FCNT_W(8)) fb_if ();

    pingpong_frame_buffer #(.COL_W(7), .ROW_W(6), .DATA_W(12), .FCNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .fb  (fb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rd_mode: 0 = no data check, 1 = data must equal e_rd, 2 = data must differ from e_rd
    typedef struct {
        string       name;
        logic        rst;
        logic        wr_en;
        logic [5:0]  wr_row;
        logic [6:0]  wr_col;
        logic [11:0] wr_data;
        logic        done;
        logic        rd_en;
        logic [5:0]  rd_row;
        logic [6:0]  rd_col;
        logic        vsync;
        logic        e_ready;
        logic        e_drop;
        logic        e_front;
        logic [7:0]  e_cnt;
        int          rd_mode;
        logic [11:0] e_rd;
    } vec_t;

    typedef struct {
        string       name;
        int          mode;
        logic [11:0] val;
    } sb_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    sb_t  sb[$];
    vec_t tbl[15];

    function automatic vec_t mk(input string nm, input int r, input int we, input int wrow,
                                input int wcol, input int wd, input int dn, input int re,
                                input int rrow, input int rcol, input int vs, input int er,
                                input int ed, input int ef, input int ec, input int md,
                                input int erd);
        vec_t v;
        v.name = nm;        v.rst = 1'(r);         v.wr_en = 1'(we);
        v.wr_row = 6'(wrow); v.wr_col = 7'(wcol);  v.wr_data = 12'(wd);
        v.done = 1'(dn);    v.rd_en = 1'(re);      v.rd_row = 6'(rrow);
        v.rd_col = 7'(rcol); v.vsync = 1'(vs);     v.e_ready = 1'(er);
        v.e_drop = 1'(ed);  v.e_front = 1'(ef);    v.e_cnt = 8'(ec);
        v.rd_mode = md;     v.e_rd = 12'(erd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
        n_cmp = n_cmp + 1;
        if (act === bad) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected anything but 0x%0h", nm, act, bad);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        rst                  = v.rst;
        fb_if.wr_en          = v.wr_en;
        fb_if.wr_row         = v.wr_row;
        fb_if.wr_col         = v.wr_col;
        fb_if.wr_data        = v.wr_data;
        fb_if.wr_frame_done  = v.done;
        fb_if.rd_en          = v.rd_en;
        fb_if.rd_row         = v.rd_row;
        fb_if.rd_col         = v.rd_col;
        fb_if.rd_vsync       = v.vsync;
        if (v.rd_en) begin
            e.name = v.name;
            e.mode = v.rd_mode;
            e.val  = v.e_rd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({v.name, ".wr_ready"},   32'(fb_if.wr_ready),   32'(v.e_ready));
        chk({v.name, ".wr_drop"},    32'(fb_if.wr_drop),    32'(v.e_drop));
        chk({v.name, ".front_bank"}, 32'(fb_if.front_bank), 32'(v.e_front));
        chk({v.name, ".frame_cnt"},  32'(fb_if.frame_cnt),  32'(v.e_cnt));
        chk({v.name, ".rd_valid"},   32'(fb_if.rd_valid),   32'(v.rd_en & ~v.rst));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (fb_if.rd_valid) begin
                if (e.mode == 1) begin
                    chk({e.name, ".rd_data"}, 32'(fb_if.rd_data), 32'(e.val));
                end else if (e.mode == 2) begin
                    chk_ne({e.name, ".rd_data"}, 32'(fb_if.rd_data), 32'(e.val));
                end
            end
        end else if (!v.rd_en && v.rd_mode == 1) begin
            chk({v.name, ".rd_data_hold"}, 32'(fb_if.rd_data), 32'(v.e_rd));
        end
    endtask

    initial begin
        logic       f;
        logic [7:0] c;

        rst = 1'b1;
        fb_if.wr_en = 1'b0;  fb_if.wr_row = 6'd0;  fb_if.wr_col = 7'd0;  fb_if.wr_data = 12'd0;
        fb_if.wr_frame_done = 1'b0; fb_if.rd_en = 1'b0; fb_if.rd_row = 6'd0; fb_if.rd_col = 7'd0;
        fb_if.rd_vsync = 1'b0;

        //                name               rst we wr  wc wdata  dn re rr rc vs  rdy drp frt cnt md  e_rd
        tbl[0]  = mk("reset",              1, 0, 0, 0, 0,     0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 'h000);
        tbl[1]  = mk("wr_abc",             0, 1, 3, 5, 'hABC, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 'h000);
        tbl[2]  = mk("rd_pre_swap",        0, 0, 0, 0, 0,     0, 1, 3, 5, 0,  1, 0, 0, 0, 2, 'hABC);
        tbl[3]  = mk("wr_with_done",       0, 1, 0, 0, 'h222, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 'h000);
        tbl[4]  = mk("wr_in_full",         0, 1, 0, 0, 'h111, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 'h000);
        tbl[5]  = mk("swap1",              0, 0, 0, 0, 0,     0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 'h000);
        tbl[6]  = mk("rd_abc",             0, 0, 0, 0, 0,     0, 1, 3, 5, 0,  1, 1, 1, 1, 1, 'hABC);
        tbl[7]  = mk("rd_finished_00",     0, 0, 0, 0, 0,     0, 1, 0, 0, 0,  1, 1, 1, 1, 1, 'h222);
        tbl[8]  = mk("wr_def",             0, 1, 3, 5, 'hDEF, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 'h000);
        tbl[9]  = mk("done_and_vsync",     0, 0, 0, 0, 0,     1, 0, 0, 0, 1,  0, 1, 1, 1, 0, 'h000);
        tbl[10] = mk("rd_still_front1",    0, 0, 0, 0, 0,     0, 1, 3, 5, 0,  0, 1, 1, 1, 1, 'hABC);
        tbl[11] = mk("rd_in_swap",         0, 0, 0, 0, 0,     0, 1, 3, 5, 1,  1, 1, 0, 2, 1, 'hABC);
        tbl[12] = mk("rd_after_swap",      0, 0, 0, 0, 0,     0, 1, 3, 5, 0,  1, 1, 0, 2, 1, 'hDEF);
        tbl[13] = mk("vsync_filling",      0, 0, 0, 0, 0,     0, 0, 0, 0, 1,  1, 1, 0, 2, 0, 'h000);
        tbl[14] = mk("rd_hold",            0, 0, 0, 0, 0,     0, 0, 0, 0, 0,  1, 1, 0, 2, 1, 'hDEF);

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
        end

        // 256 swaps: frame_cnt passes through 0 and returns to its start value
        f = 1'b0;
        c = 8'd2;
        for (int i = 0; i < 256; i++) begin
            apply(mk("wrap_done",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, int'(f), int'(c), 0, 0));
            f = ~f;
            c = c + 8'd1;
            apply(mk("wrap_vsync", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, int'(f), int'(c), 0, 0));
        end

        // Reset in the middle of a fill, then the next frame lands in bank 1
        apply(mk("partial_wr",     0, 1, 1, 1, 'h777, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 'h000));
        apply(mk("rst_mid_fill",   1, 1, 1, 2, 'h555, 0, 1, 3, 5, 0, 1, 0, 0, 0, 0, 'h000));
        apply(mk("post_rst_data",  0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 'h000));
        apply(mk("wr_3c3",         0, 1, 1, 1, 'h3C3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h000));
        apply(mk("done_after_rst", 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000));
        apply(mk("swap_after_rst", 0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 'h000));
        apply(mk("rd_bank1_3c3",   0, 0, 0, 0, 0,     0, 1, 1, 1, 0, 1, 0, 1, 1, 1, 'h3C3));
        apply(mk("idle_end",       0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 'h3C3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
